// File: rtl/memory_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data stage.
// Optional fetch anti-starvation counter enabled by defining ARB_STARVE_GUARD_EN.
module memory_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_ack_o,
  output logic [31:0] inst_data_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_wmask_i,
  output logic        data_ack_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INST_ACCESS,
    S_DATA_ACCESS,
    S_RESPOND
  } state_t;

  state_t r_state;
  logic   w_grant_inst;
  logic   w_grant_data;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("memory_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  // Fetch overrides data only once enough data grants have passed it by.
  assign w_grant_inst = inst_req_i && (!data_req_i || (r_starve_cnt >= 4'(STARVE_LIMIT)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_inst) begin
        r_starve_cnt <= '0;
      end else if (w_grant_data && inst_req_i && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_grant_inst = inst_req_i && !data_req_i;
`endif

  assign w_grant_data = data_req_i && !w_grant_inst;

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values between lines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_wmask_o  <= '0;
      inst_ack_o   <= 1'b0;
      inst_data_o  <= '0;
      data_ack_o   <= 1'b0;
      data_rdata_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
            mem_wmask_o <= data_wmask_i;
            busy_o      <= 1'b1;
            r_state     <= S_DATA_ACCESS;
          end else if (w_grant_inst) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= inst_addr_i;
            mem_wmask_o <= 4'hF;
            busy_o      <= 1'b1;
            r_state     <= S_INST_ACCESS;
          end
        end
        S_INST_ACCESS: begin
          if (mem_ready_i) begin
            mem_req_o   <= 1'b0;
            inst_data_o <= mem_rdata_i;
            inst_ack_o  <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_DATA_ACCESS: begin
          if (mem_ready_i) begin
            mem_req_o  <= 1'b0;
            if (!mem_we_o) begin
              data_rdata_o <= mem_rdata_i;
            end
            data_ack_o <= 1'b1;
            r_state    <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          // Requests are not sampled here: the acked requester still holds req.
          inst_ack_o <= 1'b0;
          data_ack_o <= 1'b0;
          busy_o     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single instruction/data memory port between the fetch stage (instruction reads) and the memory stage (loads/stores). Accepts one request at a time through a grant state machine, drives the memory port with latched request fields, and returns read data with a one-cycle acknowledge. Data-side requests have priority. An optional counter prevents fetch starvation.

## Interface
- STARVE_LIMIT, 4: consecutive data grants, made while fetch is waiting, before fetch is forced through. Range 1..15. Used only with `ARB_STARVE_GUARD_EN`.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- inst_req_i  in  1  fetch read request; held high until inst_ack_o
- inst_addr_i  in  32  fetch address; held stable while inst_req_i is high
- inst_ack_o  out  1  one-cycle pulse; inst_data_o is valid in this cycle
- inst_data_o  out  32  registered instruction word
- data_req_i  in  1  memory-stage request; held high until data_ack_o
- data_we_i  in  1  1 = store, 0 = load
- data_addr_i  in  32  load/store address
- data_wdata_i  in  32  store data
- data_wmask_i  in  4  store byte enables
- data_ack_o  out  1  one-cycle completion pulse
- data_rdata_o  out  32  registered load data
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_wmask_o  out  4  memory byte enables
- mem_ready_i  in  1  memory completes the access this cycle; mem_rdata_i is valid
- mem_rdata_i  in  32  memory read data
- busy_o  out  1  high in any state other than IDLE

## Operation
- The state machine has four states: IDLE, INST_ACCESS, DATA_ACCESS and RESPOND.
- IDLE:
  - If data_req_i is high, latch the data fields and go to DATA_ACCESS.
  - Otherwise, if inst_req_i is high, latch inst_addr_i with we=0 and mask=4'hF, and go to INST_ACCESS.
  - If neither is high, stay in IDLE.
- INST_ACCESS and DATA_ACCESS:
  - mem_req_o=1 and the mem_* outputs come from the latched fields.
  - These outputs stay constant until mem_ready_i is seen.
  - On mem_ready_i, capture mem_rdata_i into inst_data_o or data_rdata_o, and go to RESPOND.
  - For stores, data_rdata_o is not updated.
- RESPOND:
  - Pulse the matching ack for exactly one cycle. mem_req_o=0.
  - No request is sampled in this state, because the requester is still holding req during it.
  - Unconditionally return to IDLE.
- Requester protocol: req must drop in the cycle after its ack. If req is still high in IDLE, that is a new request.
- A requester that drops req before its ack still gets a completed access and an ack. Aborting an access is not supported.
- When not in an ACCESS state, mem_we_o, mem_addr_o, mem_wdata_o and mem_wmask_o hold their last latched values; only mem_req_o qualifies them.
- inst_data_o and data_rdata_o hold their values until the next capture.

## Timing
- Minimum latency, with the request sampled in IDLE at cycle 0:
  - Cycle 1: mem_req_o=1.
  - If mem_ready_i is high in cycle 1, ack is high in cycle 2.
  - Cycle 3: back in IDLE.
- Each wait cycle of mem_ready_i adds one cycle. There is no timeout.
- Peak throughput is one access per 3 cycles.
- Simultaneous requests in IDLE: data wins. Fetch is granted on the next IDLE visit, unless another data request is pending.
- Reset values, taking effect on the first clock edge with rst_i high:
  - State = IDLE.
  - All outputs = 0, including mem_addr_o, inst_data_o and data_rdata_o.
  - Latched fields and the starvation counter = 0.
- Reset in the middle of an access drops mem_req_o at that edge. No ack is issued for the interrupted access.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit starve counter increments on each data grant made while inst_req_i is high. It saturates at 15.
  - The counter clears on any instruction grant.
  - If both requests are present in IDLE and starve counter ≥ STARVE_LIMIT, fetch is granted instead of data.
- Undefined: strict data priority. No counter is present, and STARVE_LIMIT is ignored.

## Test plan
- Fetch alone, with inst_req_i=1, addr=0x8000_0000 and mem_ready_i tied high:
  - mem_req_o=1 with mem_addr_o=0x8000_0000 and mem_wmask_o=4'hF in cycle 1.
  - inst_ack_o=1 with inst_data_o equal to the memory word in cycle 2.
  - busy_o=0 in cycle 3.
- Store with wait states: addr=0x8000_0100, wdata=0xDEADBEEF, mask=4'b0011, and mem_ready_i delayed 3 cycles:
  - mem_* fields are held constant for 4 cycles.
  - data_ack_o is a single pulse.
  - data_rdata_o is unchanged.
- Simultaneous inst and data requests in IDLE:
  - The data access is issued first.
  - Fetch is issued right after RESPOND.
  - inst_ack_o arrives 3 cycles after data_ack_o (zero-wait memory).
- Starvation with guard enabled, STARVE_LIMIT=4, inst_req_i held high, and data_req_i re-requesting every IDLE:
  - Exactly 4 data grants occur, then 1 instruction grant, then data resumes.
  - Without the macro, fetch is never granted.
- Reset asserted in INST_ACCESS:
  - The next cycle has mem_req_o=0, inst_ack_o=0, busy_o=0 and inst_data_o=0.
  - A fresh request afterwards completes normally.
